// File: rtl/qspi_rom_reader_pkg.sv
// Shared constants, FSM state type and per-state nibble counts for the
// quad-SPI cartridge ROM reader.
package qspi_pkg;

  localparam logic [7:0] QSPI_OP_QREAD  = 8'hEB;
  localparam logic [7:0] QSPI_MODE_CONT = 8'hA0;
  localparam logic [7:0] QSPI_MODE_NONE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    MODE,
    DUMMY,
    DATA,
    DONE
  } qspi_state_t;

  localparam logic [3:0] CMD_NIBBLES  = 4'd2;
  localparam logic [3:0] ADDR_NIBBLES = 4'd6;
  localparam logic [3:0] MODE_NIBBLES = 4'd2;
  localparam logic [3:0] DATA_NIBBLES = 4'd2;

  // Index of the last nibble (SCK cycle) spent in a serial phase.
  function automatic logic [3:0] last_nibble(input qspi_state_t st,
                                             input logic [3:0] dummy_cycles);
    logic [3:0] idx;
    case (st)
      CMD:     idx = CMD_NIBBLES - 4'd1;
      ADDR:    idx = ADDR_NIBBLES - 4'd1;
      MODE:    idx = MODE_NIBBLES - 4'd1;
      DUMMY:   idx = dummy_cycles - 4'd1;
      DATA:    idx = DATA_NIBBLES - 4'd1;
      default: idx = 4'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/qspi_rom_reader_if.sv
// Request/response bus between the CPU-side requester and the ROM reader.
// master = requester, slave = qspi_rom_reader.
interface qspi_rom_reader_if #(
  parameter int ADDR_BITS = 12
) ();
  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_BITS-1:0] req_addr;
  logic                 rd_valid;
  logic [7:0]           rd_data;
  logic                 busy;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rd_valid, rd_data, busy
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/qspi_rom_reader.sv
// Quad-SPI fast-read (0xEB) byte fetcher for the cartridge ROM window.
// One byte per accepted request; SCK runs at clk/2 while chip select is low.
// Optional build macro QSPI_CONT_READ_EN: sends mode byte 0xA0 and, after
// the first completed read, skips the command phase on later requests.
module qspi_rom_reader
  import qspi_pkg::*;
#(
  parameter int          ADDR_BITS    = 12,
  parameter logic [23:0] ROM_BASE     = 24'h000000,
  parameter int          DUMMY_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  qspi_rom_reader_if.slave  bus,
  output logic              qspi_cs_n,
  output logic              qspi_sck,
  output logic [3:0]        qspi_io_out,
  output logic [3:0]        qspi_io_oe,
  input  logic [3:0]        qspi_io_in
);

`ifdef QSPI_CONT_READ_EN
  localparam logic [7:0] MODE_BYTE = QSPI_MODE_CONT;
`else
  localparam logic [7:0] MODE_BYTE = QSPI_MODE_NONE;
`endif

  localparam logic [3:0] DUMMY_NIB = 4'(DUMMY_CYCLES);

  qspi_state_t state_reg, state_next;
  qspi_state_t first_state;
  logic [3:0]  nib_cnt_reg;
  logic        phase_reg;
  logic [23:0] shift_out_reg;
  logic [7:0]  shift_in_reg;
  logic        rd_valid_reg;
  logic [7:0]  rd_data_reg;
  logic [23:0] flash_addr;
  logic        active;
  logic        accept;
  logic        nib_end;

  // Upper flash address bits come from ROM_BASE; the flash wraps on its own.
  assign flash_addr = ROM_BASE | {{(24-ADDR_BITS){1'b0}}, bus.req_addr};

  assign active  = state_reg inside {CMD, ADDR, MODE, DUMMY, DATA};
  // Not ready while rd_valid pulses so cs_n stays high between transfers.
  assign accept  = (state_reg == IDLE) && !rd_valid_reg && bus.req_valid;
  assign nib_end = active && phase_reg &&
                   (nib_cnt_reg == last_nibble(state_reg, DUMMY_NIB));

  assign qspi_cs_n     = !active;
  assign qspi_sck      = active && phase_reg;
  assign bus.req_ready = (state_reg == IDLE) && !rd_valid_reg;
  assign bus.busy      = (state_reg != IDLE) || rd_valid_reg;
  assign bus.rd_valid  = rd_valid_reg;
  assign bus.rd_data   = rd_data_reg;

`ifdef QSPI_CONT_READ_EN
  logic cont_mode_reg;

  // Flash stays in continuous-read mode once a full read with mode 0xA0 ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      cont_mode_reg <= 1'b0;
    end else if (state_reg == DONE) begin
      cont_mode_reg <= 1'b1;
    end
  end

  assign first_state = cont_mode_reg ? ADDR : CMD;
`else
  assign first_state = CMD;
`endif

  // Next-state decode and the nibble/output-enable driven in each phase.
  always_comb begin
    state_next  = state_reg;
    qspi_io_out = 4'h0;
    qspi_io_oe  = 4'h0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = first_state;
      end
      CMD: begin
        qspi_io_oe  = 4'hF;
        qspi_io_out = nib_cnt_reg[0] ? QSPI_OP_QREAD[3:0] : QSPI_OP_QREAD[7:4];
        if (nib_end) state_next = ADDR;
      end
      ADDR: begin
        qspi_io_oe  = 4'hF;
        qspi_io_out = shift_out_reg[23:20];
        if (nib_end) state_next = MODE;
      end
      MODE: begin
        qspi_io_oe  = 4'hF;
        qspi_io_out = nib_cnt_reg[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
        if (nib_end) state_next = DUMMY;
      end
      DUMMY: begin
        if (nib_end) state_next = DATA;
      end
      DATA: begin
        if (nib_end) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, SCK phase, nibble counter, shift registers and read-data output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      nib_cnt_reg   <= 4'd0;
      phase_reg     <= 1'b0;
      shift_out_reg <= 24'h0;
      shift_in_reg  <= 8'h00;
      rd_valid_reg  <= 1'b0;
      rd_data_reg   <= 8'h00;
    end else begin
      state_reg    <= state_next;
      rd_valid_reg <= (state_reg == DONE);
      if (state_reg == DONE) rd_data_reg <= shift_in_reg;

      if (accept) begin
        shift_out_reg <= flash_addr;
        nib_cnt_reg   <= 4'd0;
        phase_reg     <= 1'b0;
      end else if (active) begin
        phase_reg <= ~phase_reg;
        if (phase_reg) begin
          nib_cnt_reg <= nib_end ? 4'd0 : nib_cnt_reg + 4'd1;
          if (state_reg == ADDR) shift_out_reg <= {shift_out_reg[19:0], 4'h0};
          // Flash nibble sampled at the edge that ends the SCK-high phase.
          if (state_reg == DATA) shift_in_reg <= {shift_in_reg[3:0], qspi_io_in};
        end
      end else begin
        phase_reg   <= 1'b0;
        nib_cnt_reg <= 4'd0;
      end
    end
  end

endmodule
